activation_arbiter: RTL

ACTIVATION_ARBITER -- requirements
Module: activation_arbiter

---
 rtl/activation_arbiter_pkg.sv | 20 ++
 rtl/activation_arbiter_if.sv | 25 ++
 rtl/activation_arbiter_rr_pick.sv | 34 +++
 rtl/activation_arbiter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/activation_arbiter_pkg.sv
// Shared layer package: arbiter FSM encoding, operand width constants and the pointer wrap helper.
package activation_arbiter_pkg;

  localparam int INTEGER_WIDTH  = 10;
  localparam int FRACTION_WIDTH = 10;
  localparam int ACT_W          = INTEGER_WIDTH + FRACTION_WIDTH;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    RESPOND = 3'd3,
    RECOVER = 3'd4
  } state_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/activation_arbiter_if.sv
// Requester-side bus of the activation arbiter (master = layer datapaths, slave = arbiter).
interface activation_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int W       = activation_arbiter_pkg::ACT_W
) ();
  // Handshake: a requester holds req[i] high (with stable req_data) until it sees its
  // one-cycle rsp_valid[i]; gnt[i] marks ownership of the core, rsp_err is qualified by rsp_valid.
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*W-1:0] req_data;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [W-1:0]         rsp_data;
  logic                 rsp_err;
  logic                 busy;

  modport master (
    output req, req_data,
    input  gnt, rsp_valid, rsp_data, rsp_err, busy
  );

  modport slave (
    input  req, req_data,
    output gnt, rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/activation_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit at or above ptr, wrapping to bit 0.
module activation_arbiter_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any
);

  // Two passes avoid a modulo: bits at/above ptr have priority, then the wrapped low bits.
  always_comb begin
    winner  = '0;
    win_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && req[i] && (IDX_W'(i) >= ptr)) begin
        any       = 1'b1;
        winner[i] = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && req[i]) begin
        any       = 1'b1;
        winner[i] = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/activation_arbiter.sv
// Round-robin arbiter sharing one external sigmoid core among NUM_REQ layer datapaths.
// Optional WAIT watchdog enabled by defining ACT_ARB_TIMEOUT_EN.
module activation_arbiter
  import activation_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int integer_width  = INTEGER_WIDTH,
  parameter int fraction_width = FRACTION_WIDTH,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int W             = integer_width + fraction_width,
  localparam int IDX_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  activation_arbiter_if.slave  bus,
  output logic                 sig_reset,
  output logic                 sig_enable,
  output logic [W-1:0]         sig_input,
  input  logic                 sig_done,
  input  logic [W-1:0]         sig_output,
  output state_t               fsm_state,
  output logic [CNT_W-1:0]     wait_count
);

  state_t               state, state_next;
  logic [IDX_W-1:0]     rr_ptr, win_idx, pick_idx;
  logic [NUM_REQ-1:0]   pick_onehot, gnt_q;
  logic                 pick_any;
  logic [W-1:0]         pick_data, sig_input_q, rsp_data_q;
  logic [CNT_W-1:0]     wait_cnt;
  logic                 timeout_hit;

  activation_arbiter_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) rr_pick (
    .req     (bus.req),
    .ptr     (rr_ptr),
    .winner  (pick_onehot),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) pick_data = bus.req_data[i*W +: W];
    end
  end

  // Counts consecutive WAIT cycles without sig_done; saturates so an unbounded wait stays sane.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == WAIT && !sig_done) begin
      if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

`ifdef ACT_ARB_TIMEOUT_EN
  logic rsp_err_q;
  assign timeout_hit = (state == WAIT) && !sig_done &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_err_q <= 1'b0;
    end else if (state == WAIT) begin
      if (sig_done)         rsp_err_q <= 1'b0;
      else if (timeout_hit) rsp_err_q <= 1'b1;
    end
  end
  assign bus.rsp_err = rsp_err_q;
`else
  assign timeout_hit = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (pick_any) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (sig_done || timeout_hit) state_next = RESPOND;
      RESPOND: state_next = RECOVER;
      RECOVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr      <= '0;
      win_idx     <= '0;
      gnt_q       <= '0;
      sig_input_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            gnt_q       <= pick_onehot;
            win_idx     <= pick_idx;
            sig_input_q <= pick_data;
          end
        end
        WAIT: begin
          if (sig_done)         rsp_data_q <= sig_output;
          else if (timeout_hit) rsp_data_q <= '0;
        end
        RESPOND: gnt_q  <= '0;
        RECOVER: rr_ptr <= IDX_W'(wrap_inc(int'(win_idx), NUM_REQ));
        default: ;
      endcase
    end
  end

  // The core is held in reset whenever it is not owned by a transaction.
  assign sig_reset     = (state == IDLE) || (state == RECOVER);
  assign sig_enable    = (state == ISSUE) || (state == WAIT);
  assign sig_input     = sig_input_q;
  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = (state == RESPOND) ? gnt_q : '0;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = (state != IDLE);
  assign fsm_state     = state;
  assign wait_count    = wait_cnt;

endmodule
